conv_layer_sequencer: RTL and testbench

Top-level sequencer for one convolution layer pass. It accepts a start handshake and waits for the weight buffer to be loaded. It then drives the enable and reset of weight_addrgener_param_2 and the input-feature address path, stepping through every output pixel of every output-map group. It also frames the accumulator with clear/valid strobes, absorbs downstream back-pressure, drains the MAC pipeline, and reports done. It sits between the layer-level host controller and the conv datapath.

---
 rtl/conv_layer_sequencer_pkg.sv | 21 ++
 rtl/sequencer_valid_pipe.sv | 31 +++
 rtl/conv_layer_sequencer.sv | 146 ++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_layer_sequencer_pkg.sv
// Shared constants and state encoding for the convolution layer sequencer.
// Defaults describe the production layer; instances may override them.
package conv_layer_sequencer_pkg;

  localparam int DEF_NUM_ONEMULT           = 4;
  localparam int DEF_OUT_FEATURE_WIDTH     = 8;
  localparam int DEF_NUM_ONE_PIXEL_CYCLE   = 13;
  localparam int DEF_PIPE_DEPTH            = 3;
  localparam int DEF_CYC_BITWIDTH          = 8;
  localparam int DEF_OUTPIXEL_BITWIDTH     = 12;
  localparam int DEF_NUM_MULTCOMP_BITWIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/sequencer_valid_pipe.sv
// PIPE_DEPTH-deep 1-bit shift register that delays acc_last into result_valid.
// The synchronous active-low clear flushes every stage at once.
module sequencer_valid_pipe #(
  parameter int PIPE_DEPTH = 3
) (
  input  logic clk,
  input  logic clear_n,
  input  logic shift_en,
  input  logic din,
  output logic dout
);

  logic [PIPE_DEPTH-1:0] pipe_r;

  // shift stages toward the output while the MAC pipe advances
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      pipe_r <= '0;
    end else if (shift_en) begin
      pipe_r[0] <= din;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end else begin
      pipe_r <= pipe_r;
    end
  end

  assign dout = pipe_r[PIPE_DEPTH-1];

endmodule

// File: rtl/conv_layer_sequencer.sv
// Sequences one convolution layer pass: waits for weights, steps every pixel of
// every output-map group, frames the accumulator and drains the MAC pipe.
module conv_layer_sequencer
  import conv_layer_sequencer_pkg::*;
#(
  parameter int NUM_ONEMULT           = DEF_NUM_ONEMULT,
  parameter int OUT_FEATURE_WIDTH     = DEF_OUT_FEATURE_WIDTH,
  parameter int NUM_ONE_PIXEL_CYCLE   = DEF_NUM_ONE_PIXEL_CYCLE,
  parameter int PIPE_DEPTH            = DEF_PIPE_DEPTH,
  parameter int CYC_BITWIDTH          = DEF_CYC_BITWIDTH,
  parameter int OUTPIXEL_BITWIDTH     = DEF_OUTPIXEL_BITWIDTH,
  parameter int NUM_MULTCOMP_BITWIDTH = DEF_NUM_MULTCOMP_BITWIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             wbuf_ready,
  input  logic                             stall,
  output logic                             agen_enable,
  output logic                             agen_reset,
  output logic                             acc_clear,
  output logic                             acc_last,
  output logic                             result_valid,
  output logic [OUTPIXEL_BITWIDTH-1:0]     pixel_idx,
  output logic [NUM_MULTCOMP_BITWIDTH-1:0] group_idx,
  output logic                             busy,
  output logic                             done
);

  localparam int PIX_PER_GROUP = OUT_FEATURE_WIDTH * OUT_FEATURE_WIDTH;
  localparam logic [CYC_BITWIDTH-1:0]          CYC_LAST   = CYC_BITWIDTH'(NUM_ONE_PIXEL_CYCLE - 1);
  localparam logic [CYC_BITWIDTH-1:0]          CYC_ONE    = CYC_BITWIDTH'(1);
  localparam logic [OUTPIXEL_BITWIDTH-1:0]     PIX_LAST   = OUTPIXEL_BITWIDTH'(PIX_PER_GROUP - 1);
  localparam logic [OUTPIXEL_BITWIDTH-1:0]     PIX_ONE    = OUTPIXEL_BITWIDTH'(1);
  localparam logic [NUM_MULTCOMP_BITWIDTH-1:0] GRP_LAST   = NUM_MULTCOMP_BITWIDTH'(NUM_ONEMULT - 1);
  localparam logic [NUM_MULTCOMP_BITWIDTH-1:0] GRP_ONE    = NUM_MULTCOMP_BITWIDTH'(1);
  // DRAIN is sized so that done lands with the final result_valid
  localparam bit                               HAS_DRAIN  = (PIPE_DEPTH > 1);
  localparam logic [CYC_BITWIDTH-1:0]          DRAIN_LAST = CYC_BITWIDTH'(HAS_DRAIN ? PIPE_DEPTH - 2 : 0);

  seq_state_e                       state_r;
  seq_state_e                       state_nxt_s;
  logic [CYC_BITWIDTH-1:0]          cyc_r;
  logic [CYC_BITWIDTH-1:0]          drain_r;
  logic [OUTPIXEL_BITWIDTH-1:0]     pixel_r;
  logic [NUM_MULTCOMP_BITWIDTH-1:0] group_r;
  logic                             run_en_s;
  logic                             first_s;
  logic                             last_s;
  logic                             pass_end_s;
  logic                             valid_s;
  logic                             pipe_clear_n_s;
  logic                             pipe_shift_s;

  // next-state decode and strobe generation
  always_comb begin
    run_en_s    = (state_r == ST_RUN) && !stall;
    first_s     = run_en_s && (cyc_r == '0);
    last_s      = run_en_s && (cyc_r == CYC_LAST);
    pass_end_s  = last_s && (pixel_r == PIX_LAST) && (group_r == GRP_LAST);
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_LOAD;
        else       state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (wbuf_ready) state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_LOAD;
      end
      ST_RUN: begin
        if (pass_end_s) state_nxt_s = HAS_DRAIN ? ST_DRAIN : ST_DONE;
        else            state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (drain_r == DRAIN_LAST) state_nxt_s = ST_DONE;
        else                       state_nxt_s = ST_DRAIN;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // state and loop counters; loop order is cyc -> pixel -> group
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cyc_r   <= '0;
      drain_r <= '0;
      pixel_r <= '0;
      group_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_RUN: begin
          if (last_s) begin
            cyc_r <= '0;
            if (pixel_r == PIX_LAST) begin
              pixel_r <= '0;
              if (group_r == GRP_LAST) group_r <= '0;
              else                     group_r <= group_r + GRP_ONE;
            end else begin
              pixel_r <= pixel_r + PIX_ONE;
            end
          end else if (run_en_s) begin
            cyc_r <= cyc_r + CYC_ONE;
          end else begin
            cyc_r <= cyc_r;
          end
        end
        ST_DRAIN: drain_r <= drain_r + CYC_ONE;
        default: begin
          cyc_r   <= '0;
          drain_r <= '0;
          pixel_r <= '0;
          group_r <= '0;
        end
      endcase
    end
  end

  // the MAC pipe keeps moving under stall, so shifting ignores it
  assign pipe_shift_s   = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign pipe_clear_n_s = reset && (state_r != ST_DONE);

  sequencer_valid_pipe #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_valid_pipe (
    .clk      (clk),
    .clear_n  (pipe_clear_n_s),
    .shift_en (pipe_shift_s),
    .din      (last_s),
    .dout     (valid_s)
  );

  assign agen_enable  = run_en_s;
  assign agen_reset   = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign acc_clear    = first_s;
  assign acc_last     = last_s;
  assign result_valid = valid_s;
  assign pixel_idx    = pixel_r;
  assign group_idx    = group_r;
  assign busy         = (state_r != ST_IDLE);
  assign done         = (state_r == ST_DONE);

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer: small configuration (2 groups,
// 2x2 pixels, 3 cycles/pixel, depth 2) plus a 1-cycle-per-pixel instance.
module tb_conv_layer_sequencer;

  localparam int NPC = 3;
  localparam int PD  = 2;

  logic        clk, reset, start, wbuf_ready, stall;
  logic        agen_enable, agen_reset, acc_clear, acc_last, result_valid, busy, done;
  logic [11:0] pixel_idx;
  logic [3:0]  group_idx;
  logic        start1, wbuf_ready1, stall1;
  logic        agen_enable1, agen_reset1, acc_clear1, acc_last1, result_valid1, busy1, done1;
  logic [11:0] pixel_idx1;
  logic [3:0]  group_idx1;

  int checks = 0, failures = 0, cyc_cnt = 0;
  int en_cnt, clr_cnt, last_cnt, done_cnt, done_cyc, last_last_cyc;
  int en1_cnt, clr1_cnt, done1_cnt, coin_err;
  logic [15:0] en_idx_q[$], exp_idx_q[$];
  int          rv_q[$], exp_rv_q[$];
  logic        en_s, busy_s, rst_s, rv_s, clr_s, lst_s, busy1_s;
  logic [11:0] pix_s;
  logic [3:0]  grp_s;

  conv_layer_sequencer #(.NUM_ONEMULT(2), .OUT_FEATURE_WIDTH(2), .NUM_ONE_PIXEL_CYCLE(NPC), .PIPE_DEPTH(PD)) dut (
    .clk(clk), .reset(reset), .start(start), .wbuf_ready(wbuf_ready), .stall(stall),
    .agen_enable(agen_enable), .agen_reset(agen_reset), .acc_clear(acc_clear), .acc_last(acc_last),
    .result_valid(result_valid), .pixel_idx(pixel_idx), .group_idx(group_idx), .busy(busy), .done(done));

  conv_layer_sequencer #(.NUM_ONEMULT(2), .OUT_FEATURE_WIDTH(2), .NUM_ONE_PIXEL_CYCLE(1), .PIPE_DEPTH(PD)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .wbuf_ready(wbuf_ready1), .stall(stall1),
    .agen_enable(agen_enable1), .agen_reset(agen_reset1), .acc_clear(acc_clear1), .acc_last(acc_last1),
    .result_valid(result_valid1), .pixel_idx(pixel_idx1), .group_idx(group_idx1), .busy(busy1), .done(done1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // called at a negedge: sample the cycle the next posedge consumes, then advance
  task automatic step();
    #1;
    en_s = agen_enable; busy_s = busy; rst_s = agen_reset; rv_s = result_valid;
    clr_s = acc_clear; lst_s = acc_last; pix_s = pixel_idx; grp_s = group_idx; busy1_s = busy1;
    if (agen_enable === 1'b1) begin
      en_cnt++;
      en_idx_q.push_back({group_idx, pixel_idx});
    end
    if (acc_clear === 1'b1) clr_cnt++;
    if (acc_last === 1'b1) begin
      last_cnt++;
      last_last_cyc = cyc_cnt;
      exp_rv_q.push_back(cyc_cnt + PD);
    end
    if (result_valid === 1'b1) rv_q.push_back(cyc_cnt);
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc_cnt;
    end
    if (agen_enable1 === 1'b1) en1_cnt++;
    if (acc_clear1 === 1'b1) clr1_cnt++;
    if (acc_clear1 !== acc_last1) coin_err++;
    if (done1 === 1'b1) done1_cnt++;
    @(negedge clk);
    cyc_cnt++;
  endtask

  task automatic clear_obs();
    en_cnt = 0; clr_cnt = 0; last_cnt = 0; done_cnt = 0; done_cyc = -1; last_last_cyc = -100;
    en1_cnt = 0; clr1_cnt = 0; done1_cnt = 0; coin_err = 0;
    en_idx_q.delete(); exp_idx_q.delete(); rv_q.delete(); exp_rv_q.delete();
  endtask

  task automatic push_expected_order();
    for (int g = 0; g < 2; g++)
      for (int p = 0; p < 4; p++)
        for (int k = 0; k < NPC; k++) exp_idx_q.push_back({4'(g), 12'(p)});
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && done_cnt == 0; i++) step();
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL %s_timeout: got no done, expected done within 300 cycles", tag);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset();
    start = 1'b1; wbuf_ready = 1'b1; stall = 1'b0;
    start1 = 1'b1; wbuf_ready1 = 1'b1; stall1 = 1'b0;
    reset = 1'b0;
    step(); step();
    #1;
    checks++;
    if ({agen_enable, agen_reset, acc_clear, acc_last, result_valid, busy, done} !== 7'b0100000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0100000",
               {agen_enable, agen_reset, acc_clear, acc_last, result_valid, busy, done});
    end
    checks++;
    if ({group_idx, pixel_idx} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_indices: got %h expected 0000", {group_idx, pixel_idx});
    end
    checks++;
    if ({agen_reset1, busy1} !== 2'b10) begin
      failures++;
      $display("FAIL reset_dut1: got %b expected 10", {agen_reset1, busy1});
    end
    start = 1'b0; start1 = 1'b0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    clear_obs();
    push_expected_order();
    start = 1'b1; step(); start = 1'b0;
    wait_done("basic");
    checks++;
    if (en_cnt != 24) begin failures++; $display("FAIL basic_enables: got %0d expected 24", en_cnt); end
    checks++;
    if (clr_cnt != 8 || last_cnt != 8) begin
      failures++; $display("FAIL basic_strobes: got clear=%0d last=%0d expected 8/8", clr_cnt, last_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_last_cyc + PD) begin
      failures++;
      $display("FAIL basic_done: got count=%0d cyc=%0d expected 1 at %0d", done_cnt, done_cyc, last_last_cyc + PD);
    end
    checks++;
    if (rv_q.size() != 8) begin failures++; $display("FAIL basic_valid_count: got %0d expected 8", rv_q.size()); end
    while (rv_q.size() > 0 && exp_rv_q.size() > 0) begin
      int got, exp;
      got = rv_q.pop_front(); exp = exp_rv_q.pop_front();
      checks++;
      if (got != exp) begin failures++; $display("FAIL basic_valid_time: got %0d expected %0d", got, exp); end
    end
    checks++;
    if (en_idx_q.size() != exp_idx_q.size()) begin
      failures++; $display("FAIL basic_order_len: got %0d expected %0d", en_idx_q.size(), exp_idx_q.size());
    end
    while (en_idx_q.size() > 0 && exp_idx_q.size() > 0) begin
      logic [15:0] got, exp;
      got = en_idx_q.pop_front(); exp = exp_idx_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL basic_order: got %h expected %h", got, exp); end
    end
    checks++;
    if (busy_s !== 1'b0 || rv_s !== 1'b0) begin
      failures++; $display("FAIL basic_idle_after: got busy=%b valid=%b expected 0/0", busy_s, rv_s);
    end
  endtask

  task automatic test_load_wait();
    int bad;
    clear_obs();
    bad = 0;
    wbuf_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (en_s !== 1'b0 || busy_s !== 1'b1 || rst_s !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL load_wait: got %0d bad cycles expected 0", bad); end
    wbuf_ready = 1'b1;
    step();
    checks++;
    if (en_s !== 1'b0) begin failures++; $display("FAIL load_edge: got enable=%b expected 0", en_s); end
    step();
    checks++;
    if (en_s !== 1'b1) begin failures++; $display("FAIL load_run_start: got enable=%b expected 1", en_s); end
    wait_done("load");
    checks++;
    if (en_cnt != 24) begin failures++; $display("FAIL load_enables: got %0d expected 24", en_cnt); end
  endtask

  task automatic test_stall();
    int bad, rv_in_stall;
    clear_obs();
    push_expected_order();
    bad = 0; rv_in_stall = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 100 && en_cnt < 7; i++) step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (en_s !== 1'b0 || clr_s !== 1'b0 || lst_s !== 1'b0 || pix_s !== 12'd2 || grp_s !== 4'd0) bad++;
      if (rv_s === 1'b1) rv_in_stall++;
    end
    stall = 1'b0;
    wait_done("stall");
    checks++;
    if (bad != 0) begin failures++; $display("FAIL stall_freeze: got %0d bad cycles expected 0", bad); end
    checks++;
    if (rv_in_stall != 1) begin failures++; $display("FAIL stall_pending_valid: got %0d expected 1", rv_in_stall); end
    checks++;
    if (en_cnt != 24 || last_cnt != 8) begin
      failures++; $display("FAIL stall_totals: got en=%0d last=%0d expected 24/8", en_cnt, last_cnt);
    end
    checks++;
    if (en_idx_q.size() != exp_idx_q.size()) begin
      failures++; $display("FAIL stall_order_len: got %0d expected %0d", en_idx_q.size(), exp_idx_q.size());
    end
    while (en_idx_q.size() > 0 && exp_idx_q.size() > 0) begin
      logic [15:0] got, exp;
      got = en_idx_q.pop_front(); exp = exp_idx_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL stall_order: got %h expected %h", got, exp); end
    end
    while (rv_q.size() > 0 && exp_rv_q.size() > 0) begin
      int got, exp;
      got = rv_q.pop_front(); exp = exp_rv_q.pop_front();
      checks++;
      if (got != exp) begin failures++; $display("FAIL stall_valid_time: got %0d expected %0d", got, exp); end
    end
  endtask

  task automatic test_mid_reset();
    clear_obs();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 100 && en_cnt < 10; i++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    checks++;
    if ({agen_reset, agen_enable, result_valid, busy} !== 4'b1000) begin
      failures++;
      $display("FAIL midreset_outputs: got %b expected 1000", {agen_reset, agen_enable, result_valid, busy});
    end
    checks++;
    if ({group_idx, pixel_idx} !== 16'h0000) begin
      failures++; $display("FAIL midreset_indices: got %h expected 0000", {group_idx, pixel_idx});
    end
    clear_obs();
    start = 1'b1; step(); start = 1'b0;
    wait_done("midreset");
    checks++;
    if (en_cnt != 24 || done_cnt != 1) begin
      failures++; $display("FAIL midreset_rerun: got en=%0d done=%0d expected 24/1", en_cnt, done_cnt);
    end
  endtask

  task automatic test_degenerate();
    clear_obs();
    wbuf_ready1 = 1'b1;
    start1 = 1'b1;
    for (int i = 0; i < 200 && done1_cnt == 0; i++) step();
    start1 = 1'b0;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (done1_cnt != 1) begin failures++; $display("FAIL degen_single_pass: got %0d done expected 1", done1_cnt); end
    checks++;
    if (en1_cnt != 8 || clr1_cnt != 8) begin
      failures++; $display("FAIL degen_counts: got en=%0d clear=%0d expected 8/8", en1_cnt, clr1_cnt);
    end
    checks++;
    if (coin_err != 0) begin failures++; $display("FAIL degen_coincide: got %0d splits expected 0", coin_err); end
    checks++;
    if (busy1_s !== 1'b0) begin failures++; $display("FAIL degen_idle_after: got busy=%b expected 0", busy1_s); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; wbuf_ready = 1'b1; stall = 1'b0;
    start1 = 1'b0; wbuf_ready1 = 1'b1; stall1 = 1'b0;
    clear_obs();
    @(negedge clk);
    test_reset();
    test_basic();
    test_load_wait();
    test_stall();
    test_mid_reset();
    test_degenerate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
